// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver.
//   - uart_state_e    : 3-bit FSM state encoding (IDLE/START/DATA/STOP/DONE)
//   - OVERSAMPLE_DEFAULT : clocks per serial bit (one clk = one oversample tick)
//   - DATA_BITS       : payload width of one 8N1 frame
//   - SCAN_W          : length of the DFT scan chain carried by each block
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS          = 8;
  localparam int SCAN_W             = 8;

  // Encodings are fixed so the debug/DFT state port reads the same on the
  // transmitter and the receiver.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } uart_state_e;

  // True for the five defined encodings; anything else is recovered to IDLE.
  function automatic logic is_legal_state(input logic [2:0] s);
    return (s <= 3'd4);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
// Bundles the serial input and the byte-level result signals of uart_rx.
//   rx          : serial line into the receiver, idle high
//   data_out    : last correctly framed byte
//   data_valid  : one-cycle pulse, data_out is new this cycle
//   frame_error : one-cycle pulse, stop bit was sampled low
//   busy        : receiver is inside a frame
//   state       : receiver FSM state for debug/DFT observation
// Modports:
//   master : the receiver (consumes rx, produces results)
//   slave  : the environment (drives rx, observes results)
// ----------------------------------------------------------------------------
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_error;
  logic                 busy;
  logic [2:0]           state;

  modport master (
    input  rx,
    output data_out,
    output data_valid,
    output frame_error,
    output busy,
    output state
  );

  modport slave (
    output rx,
    input  data_out,
    input  data_valid,
    input  frame_error,
    input  busy,
    input  state
  );

endinterface

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous serial input into the clk domain and flags the
// 1->0 transition that marks a possible start bit.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   hold     : freezes all three flops (scan shift mode)
//   rx       : raw asynchronous serial input
//   rx_sync  : rx after two flops (rx_s2)
//   fall     : high while rx_s2 is 0 and the previous sample was 1
// ----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic rx,
  output logic rx_sync,
  output logic fall
);

  logic rx_s1;
  logic rx_s2;
  logic rx_prev;

  // Flops reset to the idle line level so leaving reset never looks like
  // a start edge. The prev flop keeps tracking the line in every state,
  // so a line that stays low cannot retrigger a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else if (!hold) begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_sync = rx_s2;
  assign fall    = !rx_s2 && rx_prev;

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, the downstream peer of uart_tx. Every clk is one
// oversample tick; a frame is start, 8 data bits LSB first, 1 stop bit.
// Each good byte is presented with a one-cycle data_valid pulse, a bad stop
// bit gives a one-cycle frame_error pulse and leaves data_out untouched.
// Ports:
//   clk          : system clock, single domain
//   rst          : synchronous active-high reset
//   bus          : uart_rx_if.master (rx, data_out, data_valid, frame_error,
//                  busy, state)
//   scan_enable  : 1 = scan shift mode, functional logic frozen
//   scan_in      : scan chain serial input
//   scan_out     : scan chain serial output (scan_chain[7])
// ----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus,
  input  logic      scan_enable,
  input  logic      scan_in,
  output logic      scan_out
);

  localparam int MID   = OVERSAMPLE / 2;
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] START_CENTRE = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] BIT_CENTRE   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(DATA_BITS - 1);

  uart_state_e          state_q;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 busy_q;
  logic [SCAN_W-1:0]    scan_chain;

  logic rx_s2;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .hold    (scan_enable),
    .rx      (bus.rx),
    .rx_sync (rx_s2),
    .fall    (rx_fall)
  );

  // Receiver FSM, counters, data path and scan chain in one clocked block.
  // After a start edge the line is re-checked half a bit later; if still
  // low, each following sample point is a full bit time apart, which puts
  // every sample near a bit centre. Edges between sample points are ignored,
  // there is no resynchronisation inside a frame.
  // Scan mode freezes every functional register (including the result
  // pulses, so a pulse that is high stays high) and only shifts the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      scan_chain  <= '0;
    end else if (scan_enable) begin
      scan_chain <= {scan_chain[SCAN_W-2:0], scan_in};
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (rx_fall) begin
            state_q  <= START;
            baud_cnt <= '0;
            busy_q   <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt == START_CENTRE) begin
            if (!rx_s2) begin
              state_q  <= DATA;
              baud_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              // Glitch shorter than half a bit: drop it silently.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == BIT_CENTRE) begin
            shift_reg <= {rx_s2, shift_reg[DATA_BITS-1:1]};
            baud_cnt  <= '0;
            if (bit_cnt == LAST_BIT) begin
              state_q <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt == BIT_CENTRE) begin
            state_q  <= DONE;
            baud_cnt <= '0;
            busy_q   <= 1'b0;
            if (rx_s2) begin
              data_q  <= shift_reg;
              valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DONE: begin
          // Pulse cycle. A start edge already arriving here is taken, so
          // back-to-back frames from uart_tx never lose a start bit.
          busy_q <= 1'b0;
          if (rx_fall) begin
            state_q  <= START;
            baud_cnt <= '0;
            busy_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.frame_error = frame_err_q;
  assign bus.busy        = busy_q;
  assign bus.state       = state_q;
  assign scan_out        = scan_chain[SCAN_W-1];

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Frames are driven serially the way
// uart_tx would drive them; expected bytes and frame errors are queued when
// a frame starts and checked by a monitor when the receiver reports.
// ----------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int OS      = 16;
  localparam int MID     = OS / 2;
  localparam int LATENCY = 3 + MID + 9 * OS;

  typedef struct {
    logic [7:0] data;
    bit         err;
    int         t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic scan_enable;
  logic scan_in;
  logic scan_out;

  uart_rx_if bus();

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .scan_enable (scan_enable),
    .scan_in     (scan_in),
    .scan_out    (scan_out)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int valid_count = 0;
  int err_count   = 0;
  int busy_falls  = 0;
  logic valid_prev = 1'b0;
  logic busy_prev  = 1'b0;
  logic [7:0] last_good = 8'h00;
  exp_t sb[$];

  // Posedge counter used to time-stamp frame starts and result pulses.
  always @(posedge clk) cyc++;

  // Scoreboard monitor: every result pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !scan_enable) begin
      if (bus.data_valid) begin
        valid_count++;
        vectors++;
        if (valid_prev) begin
          miscompares++;
          $display("[TB] FAIL valid_width: data_valid high %0d cycles, required 1", 2);
        end
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_valid: data_out=%h, no frame queued", bus.data_out);
        end else begin
          e = sb.pop_front();
          vectors++;
          if (e.err || bus.data_out !== e.data) begin
            miscompares++;
            $display("[TB] FAIL rx_byte: got valid data_out=%h, required err=%0d data=%h",
                     bus.data_out, e.err, e.data);
          end
          vectors++;
          if (cyc - e.t0 !== LATENCY) begin
            miscompares++;
            $display("[TB] FAIL valid_latency: got %0d, required %0d", cyc - e.t0, LATENCY);
          end
        end
      end
      if (bus.frame_error) begin
        err_count++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_frame_error: no frame queued");
        end else begin
          e = sb.pop_front();
          if (!e.err || bus.data_out !== e.data || bus.data_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL frame_error: got data_out=%h valid=%b, required err=%0d data=%h valid=0",
                     bus.data_out, bus.data_valid, e.err, e.data);
          end
        end
      end
      if (busy_prev && !bus.busy) busy_falls++;
      valid_prev = bus.data_valid;
      busy_prev  = bus.busy;
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Drives one frame bit-serially like uart_tx (start, 8 data LSB first,
  // stop) and queues the expected outcome.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    exp_t e;
    @(negedge clk);
    e.data = stop_bit ? b : last_good;
    e.err  = !stop_bit;
    e.t0   = cyc;
    sb.push_back(e);
    if (stop_bit) last_good = b;
    bus.rx = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (OS) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (OS) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout: %0d results outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.state !== IDLE) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %0d, required %0d", bus.state, IDLE);
    end
    vectors++;
    if (bus.busy !== 1'b0 || bus.data_valid !== 1'b0 || bus.frame_error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: busy=%b valid=%b ferr=%b, required 0 0 0",
               bus.busy, bus.data_valid, bus.frame_error);
    end
    vectors++;
    if (bus.data_out !== 8'h00 || scan_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: data_out=%h scan_out=%b, required 00 0", bus.data_out, scan_out);
    end
    rst = 1'b0;
    last_good = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loopback();
    int v0 = valid_count;
    int e0 = err_count;
    $display("[TB] loopback 0xA5");
    send_frame(8'hA5, 1'b1);
    wait_drain("loopback");
    repeat (20) @(negedge clk);
    vectors++;
    if (valid_count - v0 !== 1 || err_count - e0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL loopback_pulses: valid=%0d ferr=%0d, required 1 0",
               valid_count - v0, err_count - e0);
    end
    vectors++;
    if (bus.data_out !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL loopback_hold: data_out=%h, required a5", bus.data_out);
    end
  endtask

  task automatic test_frame_error();
    int v0 = valid_count;
    int e0 = err_count;
    $display("[TB] framing error 0x3C");
    send_frame(8'h3C, 1'b0);
    wait_drain("frame_error");
    repeat (20) @(negedge clk);
    vectors++;
    if (valid_count - v0 !== 0 || err_count - e0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL ferr_pulses: valid=%0d ferr=%0d, required 0 1",
               valid_count - v0, err_count - e0);
    end
    vectors++;
    if (bus.data_out !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL ferr_data_kept: data_out=%h, required a5", bus.data_out);
    end
  endtask

  task automatic test_false_start();
    int v0 = valid_count;
    int e0 = err_count;
    int busy_cycles = 0;
    $display("[TB] false start");
    @(negedge clk);
    bus.rx = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cycles++;
      if (i == 4) bus.rx = 1'b1;
    end
    vectors++;
    if (busy_cycles !== MID) begin
      miscompares++;
      $display("[TB] FAIL false_start_busy: got %0d cycles, required %0d", busy_cycles, MID);
    end
    vectors++;
    if (bus.state !== IDLE || valid_count != v0 || err_count != e0) begin
      miscompares++;
      $display("[TB] FAIL false_start_idle: state=%0d valid=%0d ferr=%0d, required 0 0 0",
               bus.state, valid_count - v0, err_count - e0);
    end
  endtask

  task automatic test_back_to_back();
    int v0 = valid_count;
    int b0 = busy_falls;
    $display("[TB] back-to-back 0x00 0xFF");
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_drain("back_to_back");
    repeat (20) @(negedge clk);
    vectors++;
    if (valid_count - v0 !== 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d pulses, required 2", valid_count - v0);
    end
    vectors++;
    if (busy_falls - b0 !== 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_busy_gap: got %0d busy falls, required 2", busy_falls - b0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0 = valid_count;
    int e0 = err_count;
    logic [7:0] b = 8'hC3;
    $display("[TB] reset mid-frame");
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = b[i];
      repeat (OS) @(negedge clk);
    end
    bus.rx = b[4];
    repeat (MID) @(negedge clk);
    vectors++;
    if (bus.state !== DATA) begin
      miscompares++;
      $display("[TB] FAIL mid_frame_state: got %0d, required %0d", bus.state, DATA);
    end
    bus.rx = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    vectors++;
    if (bus.state !== IDLE || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: state=%0d busy=%b, required 0 0", bus.state, bus.busy);
    end
    repeat (40) @(negedge clk);
    vectors++;
    if (valid_count != v0 || err_count != e0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_quiet: valid=%0d ferr=%0d busy=%b, required 0 0 0",
               valid_count - v0, err_count - e0, bus.busy);
    end
    send_frame(8'h5A, 1'b1);
    wait_drain("after_reset");
    repeat (10) @(negedge clk);
    vectors++;
    if (valid_count - v0 !== 1 || bus.data_out !== 8'h5A) begin
      miscompares++;
      $display("[TB] FAIL after_reset_rx: valid=%0d data_out=%h, required 1 5a",
               valid_count - v0, bus.data_out);
    end
  endtask

  task automatic test_scan();
    logic [15:0] stream = {8'b1011_0010, 8'h00};
    logic        exp_out;
    int v0 = valid_count;
    int e0 = err_count;
    $display("[TB] scan shift");
    // Freeze the receiver in the middle of a frame.
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (40) @(negedge clk);
    scan_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      scan_in = stream[15-i];
      bus.rx  = i[0];
      @(negedge clk);
      exp_out = (i >= 7) ? stream[15-(i-7)] : 1'b0;
      vectors++;
      if (scan_out !== exp_out) begin
        miscompares++;
        $display("[TB] FAIL scan_out[%0d]: got %b, required %b", i, scan_out, exp_out);
      end
      vectors++;
      if (bus.state !== DATA || bus.busy !== 1'b1 || bus.data_out !== 8'h5A ||
          bus.data_valid !== 1'b0 || bus.frame_error !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL scan_hold[%0d]: state=%0d busy=%b data=%h valid=%b ferr=%b, required 2 1 5a 0 0",
                 i, bus.state, bus.busy, bus.data_out, bus.data_valid, bus.frame_error);
      end
    end
    vectors++;
    if (valid_count != v0 || err_count != e0) begin
      miscompares++;
      $display("[TB] FAIL scan_pulses: valid=%0d ferr=%0d, required 0 0",
               valid_count - v0, err_count - e0);
    end
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    bus.rx      = 1'b1;
    rst         = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    bus.rx      = 1'b1;
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    test_reset();
    test_loopback();
    test_frame_error();
    test_false_start();
    test_back_to_back();
    test_reset_mid_frame();
    test_scan();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_left: %0d results outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; the downstream peer of the team's uart_tx, consuming the serial line it drives.
- Oversamples the serial input with the system clock; every clk is one oversample tick, matching uart_tx's 16 clocks per bit.
- Recovers 8N1 frames (start, 8 data LSB-first, 1 stop) and presents each byte with a one-cycle valid pulse.
- Carries the same 8-bit DFT scan chain hookup as uart_tx.

Parameters:
OVERSAMPLE, 16, clocks per bit; must equal uart_tx bit time; even, >= 4
MID, OVERSAMPLE/2, clocks from detected start edge to the start-bit centre

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous, active-high reset (sampled on posedge clk only)
rx  in  1  serial input; asynchronous to clk; idle high
data_out  out  8  last correctly framed byte; holds until the next good frame
data_valid  out  1  one-cycle pulse; data_out is new this cycle
frame_error  out  1  one-cycle pulse; stop bit sampled 0; data_out not updated
busy  out  1  high from start detect until the frame completes
state  out  3  current FSM state, for debug/DFT observation
scan_enable  in  1  1 = scan shift mode; functional logic frozen
scan_in  in  1  scan chain serial input
scan_out  out  1  scan_chain[7]

Behaviour:
- Reset (rst high at posedge clk) sets:
  - state=IDLE, busy=0, data_out=0, data_valid=0, frame_error=0
  - bit_cnt=0, baud_cnt=0, shift_reg=0, scan_chain=0
  - sync flops=1, prev sample=1
- Reset mid-frame aborts the frame with no pulse; the receiver is in IDLE on the first non-reset cycle.
- Input path: rx goes through 2 flops (rx_s1, rx_s2), then a prev-sample flop. A falling edge is rx_s2==0 and prev==1.
- State encodings: IDLE=0, START=1, DATA=2, STOP=3, DONE=4. Any other value goes to IDLE.
- IDLE:
  - busy=0.
  - On a falling edge: go to START, baud_cnt=0, busy=1.
  - A line held low does not retrigger; a new frame needs a 1->0 transition.
- START:
  - baud_cnt increments each clk.
  - At baud_cnt==MID-1, sample rx_s2:
    - 0: go to DATA, baud_cnt=0, bit_cnt=0.
    - 1: false start; go to IDLE, busy=0, no pulse.
- DATA:
  - baud_cnt increments each clk.
  - At baud_cnt==OVERSAMPLE-1 (bit centre): shift_reg={rx_s2, shift_reg[7:1]} (LSB first), baud_cnt=0.
  - If bit_cnt==7, go to STOP; otherwise bit_cnt+1.
- STOP:
  - At baud_cnt==OVERSAMPLE-1, sample rx_s2 and go to DONE.
  - 1: data_out<=shift_reg, data_valid=1 in the following cycle.
  - 0: frame_error=1 in the following cycle; data_out unchanged.
- DONE: the pulse cycle; busy=0; go to IDLE next clk. Pulses are registered and last exactly one cycle.
- Latency: the rx input first sampled low at posedge k gives data_valid high at posedge k+3+MID+9*OVERSAMPLE, i.e. k+155 for the default.
- Back-to-back: a start edge arriving while in DONE or IDLE is accepted. uart_tx's inter-frame gap (STOP 16 clk, DONE, IDLE) is always met.
- Mid-frame transitions: edges on rx outside the bit centres are ignored; there is no resynchronisation.
- No consumer handshake: a byte not taken on data_valid is overwritten by the next good frame.
- Scan mode (scan_enable=1):
  - scan_chain <= {scan_chain[6:0], scan_in} each clk.
  - All functional registers hold, including sync flops and the outputs data_valid and frame_error, which also hold (no new pulse).
  - rst has priority over scan_enable.

Decomposition:
- Shared package uart_pkg holds:
  - state localparams IDLE/START/DATA/STOP/DONE (3-bit), shared with uart_tx;
  - OVERSAMPLE default, DATA_BITS=8.
- One sub-module, uart_rx_sync: 2-flop synchronizer plus prev flop and falling-edge output. Resets to all-ones; has a hold input driven by scan_enable.

Test Plan:
- Loopback: uart_tx drives rx, tx_start with data_in=0xA5 -> exactly one data_valid, data_out=0xA5, frame_error never high, valid 155 clk after rx first sampled low.
- Back-to-back: bytes 0x00 then 0xFF through uart_tx with no idle gap -> two data_valid pulses, values 0x00 then 0xFF, busy low 1-2 cycles between frames.
- False start: rx low for 4 clk then high -> state returns to IDLE at the MID sample, no data_valid, no frame_error, busy pulse about 8 clk.
- Framing error: bench drives byte 0x3C with stop bit 0 -> frame_error pulse one cycle, data_valid stays 0, data_out keeps the prior 0xA5.
- Reset mid-frame: rst high for 1 clk during DATA bit 4 -> next cycle state=IDLE, busy=0, no pulse. A following 0x5A frame is received correctly.
- Scan: scan_enable=1, shift 8'b1011_0010 MSB first -> scan_out reproduces the pattern starting 8 clk later. state, data_out and busy are unchanged throughout; rx toggling during scan produces no pulse.
